vga_pix_gen: RTL and testbench
==============================

// Module: vga_pix_gen
// PURPOSE
//  - Pixel-timing source for the VGA path. Produces pix_if: raster x/y plus hs/vs/de.
//  - Drives every pixel consumer (clock/calendar drawers), which register hs/vs/de and emit colour.
//  - Default timing is 640x480@60 on the 25 MHz pixel clock; also gives frame/line strobes and a frame count.
// PARAMETERS
//  PIX_X_W   12   width of pix_if.x
//  PIX_Y_W   12   width of pix_if.y
//  H_VIS     640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_VIS     480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hs active level (0 = active-low)
//  VS_POL    0    vs active level (0 = active-low)
//  FCNT_W    16   width of frame_cnt_o
// PORTS
//  clk_25_i       in   1        pixel clock
//  rst_i          in   1        reset; asynchronous, active-high
//  en_i           in   1        timing enable; low holds the raster idle at origin
//  pix_if.x       out  PIX_X_W  column, 0..H_VIS-1 while de, else 0
//  pix_if.y       out  PIX_Y_W  row, 0..V_VIS-1 on visible lines, else 0
//  pix_if.hs      out  1        horizontal sync, level HS_POL when active
//  pix_if.vs      out  1        vertical sync, level VS_POL when active
//  pix_if.de      out  1        display enable; high on visible pixels only
//  line_start_o   out  1        1-cycle pulse on h=0 of every line
//  frame_start_o  out  1        1-cycle pulse on h=0, v=0
//  frame_cnt_o    out  FCNT_W   completed-frame count; wraps modulo 2^FCNT_W
// BEHAVIOUR
//  - Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
//  - Counters: h_cnt runs 0..H_TOT-1 and wraps to 0. v_cnt increments on the h wrap and wraps 0 after V_TOT-1.
//    Counter widths are $clog2(H_TOT) and $clog2(V_TOT).
//  - Decode, all pure functions of (h_cnt, v_cnt):
//    - de = h<H_VIS && v<V_VIS
//    - hs active for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751)
//    - vs active for V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (490..491), for the whole line
//  - All outputs are registered, one cycle after the counter state they decode.
//    x/y/hs/vs/de/strobes are mutually aligned; consumers add their own delay.
//  - Reset values: counters 0; x=0, y=0, de=0; hs=~HS_POL, vs=~VS_POL; strobes 0; frame_cnt_o=0.
//  - en_i low (synchronous):
//    - counters forced to 0 next cycle; outputs go to their reset values; frame_cnt_o holds.
//    - A mid-frame drop abandons the frame without counting it.
//  - en_i rising: the first active cycle decodes h=0, v=0. The cycle after, frame_start_o=1, line_start_o=1, de=1, x=0, y=0.
//  - frame_cnt_o increments once per frame, in the same cycle frame_start_o is asserted, except for the first frame after reset or re-enable.
//  - rst_i mid-frame: immediate asynchronous return to reset values; no partial-sync glitch guarantee beyond that.
//  - Width check: x and y must hold H_VIS-1 and V_VIS-1; elaboration $error if PIX_X_W/PIX_Y_W are too small.
// STRUCTURE
//  - vga_timing_pkg holds:
//    - default 640x480@60 localparams (the H_*/V_* values above)
//    - totals and sync-window start/end helper constants
//    - typedef pix_pos_t { x, y }
//  - One sub-module, vga_axis_cnt #(VIS,FP,SYNC,BP,POL). Interface: en, inc, cnt, wrap, vis, sync.
//    It is instantiated twice: the horizontal one with inc=1, the vertical one with inc=h wrap.
//  - Top: output registers, strobe generation, frame counter, pix_if drive.
// TESTING
//  1. Reset then en_i=1 -> cycle 1: de=1, x=0, y=0, frame_start_o=1, line_start_o=1; cycle 640: x=639, de=1; cycle 641: de=0, x=0.
//  2. Free-run one line -> hs=0 for exactly 96 cycles starting 656 cycles after line_start_o; line period 800.
//  3. Free-run one frame -> 307200 de cycles; vs=0 for 1600 cycles covering lines 490-491; frame_start_o period 420000.
//  4. Run 3 frames -> frame_cnt_o = 0,1,2,3 at successive frame_start_o pulses. Force FCNT_W=2 -> wraps 3 -> 0.
//  5. Drop en_i at v=200, h=300 -> next cycle outputs idle, frame_cnt_o unchanged. Re-raise -> restart at x=0, y=0 with frame_start_o.
//  6. Assert rst_i at v=491 with vs active -> vs=~VS_POL and de=0 immediately; after release, raster restarts at origin.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the VGA pixel path: default 640x480@60 numbers,
// window helpers and the pixel position type.
package vga_timing_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int POS_W = 12;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pix_pos_t;

  function automatic int axis_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction

  // Sync window is [vis+fp, vis+fp+sync) on either axis.
  function automatic int sync_start(int vis, int fp);
    return vis + fp;
  endfunction

  function automatic int sync_end(int vis, int fp, int sync);
    return vis + fp + sync;
  endfunction

  localparam int DEF_H_TOT        = axis_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOT        = axis_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int DEF_H_SYNC_START = sync_start(DEF_H_VIS, DEF_H_FP);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_VIS, DEF_V_FP);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: a wrapping position counter plus combinational decode of
// the visible region and the sync window (driven at its POL level when active).
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int   VIS  = DEF_H_VIS,
  parameter int   FP   = DEF_H_FP,
  parameter int   SYNC = DEF_H_SYNC,
  parameter int   BP   = DEF_H_BP,
  parameter logic POL  = 1'b0,
  localparam int  TOT  = axis_total(VIS, FP, SYNC, BP),
  localparam int  CW   = $clog2(TOT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          vis_o,
  output logic          sync_o
);

  localparam int S_START = sync_start(VIS, FP);
  localparam int S_END   = sync_end(VIS, FP, SYNC);

  logic [CW-1:0] cnt_q, cnt_d;
  int            cnt_w;

  assign cnt_w  = int'(cnt_q);
  assign wrap_o = en_i && inc_i && (cnt_w == TOT - 1);
  assign vis_o  = cnt_w < VIS;
  assign sync_o = (cnt_w >= S_START && cnt_w < S_END) ? POL : ~POL;
  assign cnt_o  = cnt_q;

  // A disabled axis parks at 0 so the next enabled cycle decodes the origin.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_pix_gen.sv
// VGA pixel-timing source: raster position, syncs, display enable, line/frame
// strobes and a completed-frame counter, all registered and mutually aligned.
module vga_pix_gen
  import vga_timing_pkg::*;
#(
  parameter int   PIX_X_W = 12,
  parameter int   PIX_Y_W = 12,
  parameter int   H_VIS   = DEF_H_VIS,
  parameter int   H_FP    = DEF_H_FP,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BP    = DEF_H_BP,
  parameter int   V_VIS   = DEF_V_VIS,
  parameter int   V_FP    = DEF_V_FP,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BP    = DEF_V_BP,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   FCNT_W  = 16
) (
  input  logic               clk_25_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [PIX_X_W-1:0] pix_x_o,
  output logic [PIX_Y_W-1:0] pix_y_o,
  output logic               pix_hs_o,
  output logic               pix_vs_o,
  output logic               pix_de_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FCNT_W-1:0]  frame_cnt_o
);

  localparam int HCW = $clog2(axis_total(H_VIS, H_FP, H_SYNC, H_BP));
  localparam int VCW = $clog2(axis_total(V_VIS, V_FP, V_SYNC, V_BP));

  if (PIX_X_W < $clog2(H_VIS) || PIX_Y_W < $clog2(V_VIS) ||
      POS_W < $clog2(H_VIS) || POS_W < $clog2(V_VIS)) begin : g_width_err
    $error("vga_pix_gen: pixel position width too small for the visible raster");
  end

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           h_wrap, h_vis, h_sync;
  logic           v_wrap, v_vis, v_sync;

  vga_axis_cnt #(
    .VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h_cnt (
    .clk_i(clk_25_i), .rst_i(rst_i), .en_i(en_i), .inc_i(1'b1),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .vis_o(h_vis), .sync_o(h_sync)
  );

  vga_axis_cnt #(
    .VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v_cnt (
    .clk_i(clk_25_i), .rst_i(rst_i), .en_i(en_i), .inc_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .vis_o(v_vis), .sync_o(v_sync)
  );

  pix_pos_t          pos_q, pos_d;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic              line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;

  // frame_done marks that the raster ran through the last pixel of a frame,
  // so only fully drawn frames are counted at the following frame start.
  always_comb begin
    pos_d         = '0;
    hs_d          = ~HS_POL;
    vs_d          = ~VS_POL;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    if (en_i) begin
      de_d          = h_vis && v_vis;
      pos_d.x       = de_d  ? POS_W'(h_cnt) : '0;
      pos_d.y       = v_vis ? POS_W'(v_cnt) : '0;
      hs_d          = h_sync;
      vs_d          = v_sync;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      frame_done_d  = frame_done_q && !frame_start_d;
      if (frame_start_d && frame_done_q) begin
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end
      if (v_wrap) begin
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q         <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pix_x_o       = PIX_X_W'(pos_q.x);
  assign pix_y_o       = PIX_Y_W'(pos_q.y);
  assign pix_hs_o      = hs_q;
  assign pix_vs_o      = vs_q;
  assign pix_de_o      = de_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pix_gen.sv
// Bench for vga_pix_gen: a default-timing instance for line-level checks and a
// tiny-raster instance (15x10, 2-bit frame count, active-high hs) for frame-level checks.
module tb_vga_pix_gen;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
  } obs_t;

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);

  logic clk_25_i = 1'b0;
  always #5 clk_25_i = ~clk_25_i;

  logic rst_s = 1'b0, en_s = 1'b0, rst_d = 1'b0, en_d = 1'b0;
  bit   cmp_on = 1'b0;
  int   checks_total = 0, checks_passed = 0;

  logic [11:0] s_x, s_y, d_x, d_y;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic        d_hs, d_vs, d_de, d_ls, d_fs;
  logic [1:0]  s_fcnt;
  logic [15:0] d_fcnt;

  vga_pix_gen #(
    .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b0), .FCNT_W(2)
  ) dut_small (
    .clk_25_i(clk_25_i), .rst_i(rst_s), .en_i(en_s),
    .pix_x_o(s_x), .pix_y_o(s_y), .pix_hs_o(s_hs), .pix_vs_o(s_vs), .pix_de_o(s_de),
    .line_start_o(s_ls), .frame_start_o(s_fs), .frame_cnt_o(s_fcnt)
  );

  vga_pix_gen dut_def (
    .clk_25_i(clk_25_i), .rst_i(rst_d), .en_i(en_d),
    .pix_x_o(d_x), .pix_y_o(d_y), .pix_hs_o(d_hs), .pix_vs_o(d_vs), .pix_de_o(d_de),
    .line_start_o(d_ls), .frame_start_o(d_fs), .frame_cnt_o(d_fcnt)
  );

  // Outputs seen p+1 cycles into an enabled run show the raster at pixel index p.
  function automatic obs_t rasterAt(int p, int hv, int hf, int hsw, int hb,
                                    int vv, int vf, int vsw, int vb, bit hpol, bit vpol);
    obs_t r;
    int htot, vtot, h, v;
    htot = hv + hf + hsw + hb;
    vtot = vv + vf + vsw + vb;
    h    = p % htot;
    v    = (p / htot) % vtot;
    r.de = (h < hv) && (v < vv);
    r.x  = r.de ? 12'(h) : 12'd0;
    r.y  = (v < vv) ? 12'(v) : 12'd0;
    r.hs = (h >= hv + hf && h < hv + hf + hsw) ? hpol : !hpol;
    r.vs = (v >= vv + vf && v < vv + vf + vsw) ? vpol : !vpol;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  function automatic obs_t idleObs(bit hpol, bit vpol);
    obs_t r;
    r    = '0;
    r.hs = !hpol;
    r.vs = !vpol;
    return r;
  endfunction

  // Behavioural model: count enabled cycles since the run began; every
  // frame-start after the first in a run adds one completed frame.
  obs_t exp_s, exp_d;
  int   s_act, s_frames, d_act, d_frames;

  always @(posedge clk_25_i or posedge rst_s) begin
    if (rst_s) begin
      s_act <= 0; s_frames <= 0; exp_s <= idleObs(1'b1, 1'b0);
    end else if (en_s) begin
      exp_s <= rasterAt(s_act, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 1'b1, 1'b0);
      if (s_act > 0 && s_act % S_FRAME == 0) s_frames <= s_frames + 1;
      s_act <= s_act + 1;
    end else begin
      s_act <= 0; exp_s <= idleObs(1'b1, 1'b0);
    end
  end

  always @(posedge clk_25_i or posedge rst_d) begin
    if (rst_d) begin
      d_act <= 0; d_frames <= 0; exp_d <= idleObs(1'b0, 1'b0);
    end else if (en_d) begin
      exp_d <= rasterAt(d_act, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      if (d_act > 0 && d_act % 420000 == 0) d_frames <= d_frames + 1;
      d_act <= d_act + 1;
    end else begin
      d_act <= 0; exp_d <= idleObs(1'b0, 1'b0);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic rs, input logic es, input logic rd, input logic ed);
    #1;
    rst_s = rs; en_s = es; rst_d = rd; en_d = ed;
  endtask

  task automatic waitCycle();
    @(posedge clk_25_i);
    @(negedge clk_25_i);
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk_25_i) begin
    if (cmp_on) begin
      checkOutput("small_stream", 64'({obs_t'({s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs}), 16'(s_fcnt)}),
                  64'({exp_s, 16'(s_frames % 4)}));
      checkOutput("def_stream", 64'({obs_t'({d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs}), d_fcnt}),
                  64'({exp_d, 16'(d_frames % 65536)}));
    end
  end

  int hs_first, hs_len, ls_next, de_n, vs_n, n_fs;
  int fs_at [6];
  int fs_cnt[6];

  initial begin
    hs_first = 0; hs_len = 0; ls_next = 0; de_n = 0; vs_n = 0; n_fs = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    cmp_on = 1'b1;
    repeat (3) waitCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycle();
    checkOutput("rst_def_de", 64'(d_de), 64'(0));
    checkOutput("rst_def_hs_vs", 64'({d_hs, d_vs}), 64'(2'b11));
    checkOutput("rst_def_fcnt", 64'(d_fcnt), 64'(0));
    checkOutput("rst_small_hs", 64'(s_hs), 64'(0));

    // Default timing: first cycle, end of visible line, hsync window, line period.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 801; k++) begin
      waitCycle();
      if (k == 1) begin
        checkOutput("def_c1_flags", 64'({d_de, d_fs, d_ls}), 64'(3'b111));
        checkOutput("def_c1_xy", 64'({d_x, d_y}), 64'(0));
      end
      if (k == 640) checkOutput("def_c640", 64'({d_de, d_x}), 64'({1'b1, 12'd639}));
      if (k == 641) checkOutput("def_c641", 64'({d_de, d_x}), 64'(0));
      if (!d_hs) begin
        if (hs_first == 0) hs_first = k;
        hs_len++;
      end
      if (k > 1 && d_ls && ls_next == 0) ls_next = k;
    end
    checkOutput("def_hs_start", 64'(hs_first), 64'(657));
    checkOutput("def_hs_len", 64'(hs_len), 64'(96));
    checkOutput("def_line_period", 64'(ls_next), 64'(801));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Small raster: one frame of de/vs, frame-count progression, then en drop at v=3,h=5.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 501; k++) begin
      waitCycle();
      if (k <= S_FRAME) begin
        if (s_de) de_n++;
        if (!s_vs) vs_n++;
      end
      if (s_fs && n_fs < 6) begin
        fs_at[n_fs] = k; fs_cnt[n_fs] = int'(s_fcnt); n_fs++;
      end
    end
    checkOutput("small_de_per_frame", 64'(de_n), 64'(48));
    checkOutput("small_vs_per_frame", 64'(vs_n), 64'(30));
    checkOutput("small_fs_count", 64'(n_fs), 64'(4));
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("small_fs_at_%0d", i), 64'(fs_at[i]), 64'(1 + S_FRAME * i));
      checkOutput($sformatf("small_fcnt_%0d", i), 64'(fs_cnt[i]), 64'(i));
    end
    checkOutput("small_pre_drop", 64'({s_x, s_y, s_fcnt}), 64'({12'd5, 12'd3, 2'd3}));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitCycle();
    checkOutput("small_drop_idle", 64'({s_x, s_y, s_de, s_hs, s_fs}), 64'(0));
    checkOutput("small_drop_fcnt", 64'(s_fcnt), 64'(3));
    waitCycle();

    // Re-enable: restart at origin, first frame uncounted, next frame wraps 3 -> 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 274; k++) begin
      waitCycle();
      if (k == 1) checkOutput("small_restart", 64'({s_fs, s_de, s_x, s_y, s_fcnt}),
                              64'({1'b1, 1'b1, 24'd0, 2'd3}));
      if (k == 151) checkOutput("small_fcnt_wrap", 64'({s_fs, s_fcnt}), 64'({1'b1, 2'd0}));
      if (k == 274) checkOutput("small_vs_active_v8", 64'({s_vs, s_de}), 64'(0));
    end

    // Asynchronous reset while vsync is active.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("small_async_rst", 64'({s_vs, s_de, s_hs, s_fcnt}), 64'({1'b1, 1'b0, 1'b0, 2'd0}));
    waitCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycle();
    checkOutput("small_post_rst", 64'({s_fs, s_ls, s_de, s_x, s_y}), 64'({3'b111, 24'd0}));
    repeat (20) waitCycle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
